// File: rtl/double_lt.sv
// double_lt: registered IEEE-754 binary64 comparator, z = (a < b).
// NaN on either side or +0/-0 pairs give 0; subnormals are compared exactly.
// Define DOUBLE_LT_INREG_EN to add 64-bit input registers (latency 1 -> 2).
module double_lt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        z
);

  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        sign_a;
  logic        sign_b;
  logic        nan_a;
  logic        nan_b;
  logic        zero_a;
  logic        zero_b;
  logic        mag_lt;
  logic        mag_gt;
  logic        lt;

`ifdef DOUBLE_LT_INREG_EN
  // Capture operands so the compare core runs from registered values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      op_a <= a;
      op_b <= b;
    end
  end
`else
  // Feed the compare core directly from the ports
  always_comb begin
    op_a = a;
    op_b = b;
  end
`endif

  // Classify operands and compare their 63-bit magnitudes
  always_comb begin
    sign_a = op_a[63];
    sign_b = op_b[63];
    nan_a  = (op_a[62:52] == 11'h7FF) && (op_a[51:0] != 52'd0);
    nan_b  = (op_b[62:52] == 11'h7FF) && (op_b[51:0] != 52'd0);
    zero_a = (op_a[62:0] == 63'd0);
    zero_b = (op_b[62:0] == 63'd0);
    mag_lt = (op_a[62:0] < op_b[62:0]);
    mag_gt = (op_a[62:0] > op_b[62:0]);
  end

  // Apply ordering rules: NaN, signed zeros, sign, then magnitude
  always_comb begin
    lt = 1'b0;
    if (nan_a || nan_b) begin
      lt = 1'b0;
    end else if (zero_a && zero_b) begin
      lt = 1'b0;
    end else if (sign_a != sign_b) begin
      lt = sign_a;
    end else if (!sign_a) begin
      lt = mag_lt;
    end else begin
      lt = mag_gt;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z <= 1'b0;
    end else begin
      z <= lt;
    end
  end

endmodule

// File: tb/tb_double_lt.sv
// Self-checking bench for double_lt: directed cases plus random stream,
// expected results queued at drive time and popped when z is due.
module tb_double_lt;

`ifdef DOUBLE_LT_INREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  localparam logic [63:0] P_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] P_TWO  = 64'h4000000000000000;
  localparam logic [63:0] N_ONE  = 64'hBFF0000000000000;
  localparam logic [63:0] N_TWO  = 64'hC000000000000000;
  localparam logic [63:0] P_ZERO = 64'h0000000000000000;
  localparam logic [63:0] N_ZERO = 64'h8000000000000000;
  localparam logic [63:0] P_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] N_INF  = 64'hFFF0000000000000;
  localparam logic [63:0] QNAN   = 64'h7FF8000000000000;

  logic        clk;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic        z;

  int unsigned tests;
  int unsigned fails;
  logic        exp_q[$];
  string       tag_q[$];

  double_lt dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Reference: real-number ordering, NaN always false
  function automatic logic model(input logic [63:0] x, input logic [63:0] y);
    real rx;
    real ry;
    if (is_nan(x) || is_nan(y)) return 1'b0;
    rx = $bitstoreal(x);
    ry = $bitstoreal(y);
    return (rx < ry) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] specials [8];
    logic [63:0] r;
    specials = '{64'h0, 64'h8000000000000000, 64'h7FF0000000000000,
                 64'hFFF0000000000000, 64'h7FF8000000000000,
                 64'h7FF0000000000001, 64'h0000000000000001,
                 64'h8000000000000001};
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       r = specials[$urandom_range(0, 7)];
      1:       r = {1'($urandom_range(0, 1)), 11'h000, r[51:0]};
      2:       r = {1'($urandom_range(0, 1)), 11'h3FF, r[51:0]};
      default: ;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic expv);
    tests++;
    assert (z === expv)
    else begin
      fails++;
      $error("FAIL %s: z=%0b expected=%0b (a=%h b=%h)", tag, z, expv, a, b);
    end
  endtask

  // Drive one operand pair, clock it, and compare whatever result is now due
  task automatic step(input logic [63:0] ta, input logic [63:0] tb_v, input string tag);
    logic  e;
    string t;
    a = ta;
    b = tb_v;
    exp_q.push_back(model(ta, tb_v));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, e);
    end else begin
      check({tag, "_warmup"}, 1'b0);
    end
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    tests = 0;
    fails = 0;

    // Reset held with operands that would otherwise give 1
    rst_n = 1'b0;
    a     = N_ONE;
    b     = P_ONE;
    #1;
    check("reset_t0", 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", 1'b0);
    end
    #2 rst_n = 1'b1;
    step(N_ONE, P_ONE, "reset_release");
    step(N_ONE, P_ONE, "reset_release2");

    // Ordinary values
    step(P_ONE, P_TWO, "one_lt_two");
    step(P_TWO, P_ONE, "two_lt_one");
    step(P_ONE, P_ONE, "one_eq_one");
    // Negatives
    step(N_TWO, N_ONE, "m2_lt_m1");
    step(N_ONE, N_TWO, "m1_lt_m2");
    // Zeros and subnormals
    step(N_ZERO, P_ZERO, "mzero_pzero");
    step(P_ZERO, N_ZERO, "pzero_mzero");
    step(P_ZERO, 64'h0000000000000001, "zero_minsub");
    step(64'h8000000000000001, P_ZERO, "nminsub_zero");
    step(64'h0000000000000002, 64'h0000000000000001, "sub_gt_sub");
    // Specials
    step(QNAN, P_ONE, "nan_a");
    step(P_ONE, QNAN, "nan_b");
    step(64'h7FF0000000000001, P_INF, "snan_inf");
    step(N_INF, P_INF, "minf_pinf");
    step(P_INF, P_INF, "pinf_pinf");
    step(N_INF, N_INF, "minf_minf");
    step(P_TWO, P_INF, "two_pinf");
    step(N_INF, N_TWO, "minf_m2");

    // Mid-stream reset: make z 1, then clear it asynchronously
    step(P_ONE, P_TWO, "pre_reset");
    step(P_ONE, P_TWO, "pre_reset2");
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", 1'b0);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    check("reset_mid_hold", 1'b0);
    #2 rst_n = 1'b1;

    // Random back-to-back stream
    for (int i = 0; i < 1000; i++) begin
      ra = rand_op();
      rb = rand_op();
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = ra ^ 64'd1;
        2: rb = {~ra[63], ra[62:0]};
        default: ;
      endcase
      step(ra, rb, "stream");
    end
    repeat (LAT - 1) step(P_ZERO, P_ZERO, "flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
